// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state type and geometry of the 16 x 32 RAM
package ram_arbiter_pkg;
  localparam int ADDRESS_LENGTH = 4;
  localparam int DATA_LENGTH = 32;
  localparam int DEPTH = 1 << ADDRESS_LENGTH;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer flips to the other port after every grant
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb gnt = !enable ? 2'b00 : &req ? (ptr ? 2'b10 : 2'b01) : req;
  always_ff @(posedge CLK)
    ptr <= RST ? 1'b0 : gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : ptr;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master round-robin front end for the 16 x 32 RAM with a hardware clear sweep
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  output logic                      BUSY,
  input  logic                      REQ0,
  input  logic                      REQ1,
  input  logic                      WE0,
  input  logic                      WE1,
  input  logic [ADDRESS_LENGTH-1:0] A0,
  input  logic [ADDRESS_LENGTH-1:0] A1,
  input  logic [DATA_LENGTH-1:0]    DI0,
  input  logic [DATA_LENGTH-1:0]    DI1,
  output logic                      GNT0,
  output logic                      GNT1,
  output logic                      RVALID0,
  output logic                      RVALID1,
  output logic [DATA_LENGTH-1:0]    DO0,
  output logic [DATA_LENGTH-1:0]    DO1,
  output logic                      RAM_EN,
  output logic                      RAM_WE,
  output logic                      RAM_RE,
  output logic [ADDRESS_LENGTH-1:0] RAM_A,
  output logic [DATA_LENGTH-1:0]    RAM_DI,
  input  logic [DATA_LENGTH-1:0]    RAM_DO
);
  state_t state, state_nx;
  logic [ADDRESS_LENGTH-1:0] cnt;
  logic [1:0] gnt, rv;
  logic clearing;
  // RST masks every combinational output so the reset cycle itself drives nothing
  assign clearing = state == CLEAR && !RST;
  rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    ({REQ1, REQ0}),
    .enable (state == IDLE && !RST),
    .gnt    (gnt)
  );
  always_comb begin
    state_nx = state;
    if (state == IDLE && CLR) state_nx = CLEAR;
    if (state == CLEAR && cnt == ADDRESS_LENGTH'(DEPTH - 1)) state_nx = IDLE;
  end
  always_ff @(posedge CLK) begin
    state <= RST ? IDLE : state_nx;
    cnt <= clearing ? cnt + 1'b1 : '0;
    rv <= RST ? 2'b00 : {gnt[1] & ~WE1, gnt[0] & ~WE0};
  end
  assign GNT0 = gnt[0];
  assign GNT1 = gnt[1];
  assign BUSY = clearing;
  assign RAM_EN = clearing | (|gnt);
  assign RAM_WE = clearing | (gnt[0] & WE0) | (gnt[1] & WE1);
  assign RAM_RE = (gnt[0] & ~WE0) | (gnt[1] & ~WE1);
  assign RAM_A = clearing ? cnt : gnt[0] ? A0 : gnt[1] ? A1 : '0;
  assign RAM_DI = gnt[0] ? DI0 : gnt[1] ? DI1 : '0;
  assign RVALID0 = rv[0];
  assign RVALID1 = rv[1];
  assign DO0 = rv[0] ? RAM_DO : '0;
  assign DO1 = rv[1] ? RAM_DO : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed traffic against a cycle-level reference model with a read-data scoreboard
module tb_ram_arbiter;
  logic CLK = 0, RST = 1, CLR = 0;
  logic REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0;
  logic [3:0] A0 = 0, A1 = 0;
  logic [31:0] DI0 = 0, DI1 = 0;
  logic BUSY, GNT0, GNT1, RVALID0, RVALID1, RAM_EN, RAM_WE, RAM_RE;
  logic [31:0] DO0, DO1, RAM_DI;
  logic [31:0] RAM_DO = 0;
  logic [3:0] RAM_A;
  logic [31:0] ram [16];
  logic [31:0] mem [16];
  logic [31:0] q0 [$], q1 [$];
  logic [31:0] ed;
  logic [1:0] g;
  logic [3:0] ca;
  logic [38:0] exp_bus;
  bit pref = 0;
  int busy = 0, checks = 0, fails = 0, cyc = 0;

  ram_arbiter dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1), .A0(A0), .A1(A1), .DI0(DI0), .DI1(DI1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1), .DO0(DO0), .DO1(DO1),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_RE(RAM_RE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  initial for (int i = 0; i < 16; i++) begin ram[i] = 0; mem[i] = 0; end

  // behavioural RAM macro: registered read, write-first not needed since one access per cycle
  always @(posedge CLK)
    if (RAM_EN) begin
      if (RAM_WE) ram[RAM_A] <= RAM_DI;
      else if (RAM_RE) RAM_DO <= ram[RAM_A];
    end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endfunction

  // reference model: one step per cycle, evaluated with inputs and combinational outputs settled
  always @(negedge CLK) begin
    cyc++;
    check("rvalid0", 64'(RVALID0), 64'(q0.size() > 0));
    if (q0.size() > 0) begin ed = q0.pop_front(); check("do0", 64'(DO0), 64'(ed)); end
    else check("do0_idle", 64'(DO0), 0);
    check("rvalid1", 64'(RVALID1), 64'(q1.size() > 0));
    if (q1.size() > 0) begin ed = q1.pop_front(); check("do1", 64'(DO1), 64'(ed)); end
    else check("do1_idle", 64'(DO1), 0);
    if (RST) begin
      pref = 0;
      busy = 0;
      q0.delete();
      q1.delete();
      check("reset_outputs", 64'({GNT1, GNT0, BUSY, RAM_EN, RAM_WE, RAM_RE, RAM_A, RAM_DI}), 0);
    end else if (busy > 0) begin
      ca = 4'(16 - busy);
      check("sweep_gnt", 64'({GNT1, GNT0}), 0);
      check("sweep_busy", 64'(BUSY), 1);
      check("sweep_bus", 64'({RAM_EN, RAM_WE, RAM_RE, RAM_A, RAM_DI}), 64'({3'b110, ca, 32'h0}));
      mem[ca] = 0;
      busy--;
    end else begin
      g = (REQ0 && REQ1) ? (pref ? 2'b10 : 2'b01) : {REQ1, REQ0};
      check("gnt", 64'({GNT1, GNT0}), 64'(g));
      check("idle_busy", 64'(BUSY), 0);
      exp_bus = '0;
      if (g[0]) begin
        exp_bus = {1'b1, WE0, ~WE0, A0, DI0};
        if (WE0) mem[A0] = DI0; else q0.push_back(mem[A0]);
        pref = 1;
      end else if (g[1]) begin
        exp_bus = {1'b1, WE1, ~WE1, A1, DI1};
        if (WE1) mem[A1] = DI1; else q1.push_back(mem[A1]);
        pref = 0;
      end
      check("ram_bus", 64'({RAM_EN, RAM_WE, RAM_RE, RAM_A, RAM_DI}), 64'(exp_bus));
      if (CLR) busy = 16;
    end
  end

  // called just after a rising edge; returns just after the edge that ends the granted cycle
  task automatic req(input int p, input bit we, input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    if (p == 0) begin REQ0 = 1; WE0 = we; A0 = a; DI0 = d; end
    else begin REQ1 = 1; WE1 = we; A1 = a; DI1 = d; end
    do begin @(negedge CLK); n++; end while (!(p == 0 ? GNT0 : GNT1) && n < 200);
    if (n >= 200) begin
      fails++;
      $display("FAIL grant_timeout port=%0d got=no-grant expected=grant within 200 cycles", p);
    end
    @(posedge CLK); #1;
    if (p == 0) REQ0 = 0; else REQ1 = 0;
  endtask

  task automatic pulse_clr();
    CLR = 1;
    @(posedge CLK); #1;
    CLR = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic random_master(input int p);
    repeat (40) begin
      idle($urandom_range(0, 2));
      req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    idle(2);
    RST = 0;
    idle(1);
    req(0, 1, 3, 32'hDEADBEEF);
    req(0, 0, 3, 0);
    idle(2);
    fork
      begin req(0, 0, 1, 0); req(0, 0, 1, 0); end
      begin req(1, 0, 2, 0); req(1, 0, 2, 0); end
    join
    for (int i = 0; i < 16; i++) req(0, 1, 4'(i), 32'hA5A5A5A5);
    pulse_clr();
    for (int i = 0; i < 16; i++) req(1, 0, 4'(i), 0);
    fork
      req(1, 0, 5, 0);
      pulse_clr();
    join
    idle(3);
    req(0, 0, 6, 0);
    for (int i = 0; i < 16; i++) req(1, 1, 4'(i), 32'h12345678 + i);
    pulse_clr();
    idle(4);
    RST = 1;
    idle(1);
    RST = 0;
    for (int i = 0; i < 16; i++) req(0, 0, 4'(i), 0);
    req(1, 1, 7, 32'hCAFEF00D);
    fork
      req(0, 0, 7, 0);
      pulse_clr();
    join
    req(0, 0, 7, 0);
    fork
      random_master(0);
      random_master(1);
      repeat (3) begin idle($urandom_range(10, 30)); pulse_clr(); end
    join
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
